// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand path: skewer FSM states,
// default array geometry and the zero-drain length helper.
package sa_pkg;

  typedef enum logic [1:0] {
    SKW_IDLE   = 2'd0,
    SKW_STREAM = 2'd1,
    SKW_FLUSH  = 2'd2
  } skw_state_e;

  localparam int unsigned SA_WIDTH = 8;
  localparam int unsigned SA_HPE   = 8;
  localparam int unsigned SA_VPE   = 8;

  // Cycles of zero injection needed to push the last skewed vector through
  // the whole array (longest diagonal of an hpe x vpe grid).
  function automatic int unsigned flush_len(input int unsigned hpe, input int unsigned vpe);
    return hpe + vpe - 1;
  endfunction

endpackage

// File: rtl/sa_delay_line.sv
// Fixed-depth shift chain used for one operand lane of the skewer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : value loaded into the head register every cycle
//   dout       : tail register (din delayed by DEPTH cycles)
module sa_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Unconditional shift; the head is index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_operand_skewer.sv
// Operand feeder for the systolic array: accepts one A vector (HPE lanes) and
// one B vector (VPE lanes) per cycle, skews lane i by i+1 register stages,
// and drains the array with FLUSH_LEN zero cycles after the last vector.
// Ports:
//   CLK, RST         : clock, asynchronous active-low reset
//   in_valid/in_ready: input handshake (in_ready decoded from state only)
//   in_last          : marks final vector pair of a frame (on accept)
//   in_a, in_b       : packed lane data, lane i at [i*WIDTH +: WIDTH]
//   AA, BB           : skewed operands to the array
//   busy             : frame in progress (STREAM or FLUSH)
//   frame_done       : one-cycle pulse when the drain completes
//   vec_count        : vectors accepted in current frame (SKEW_STATS_EN only)
// Build option: define SKEW_STATS_EN to add the vec_count port and counter.
module sa_operand_skewer
  import sa_pkg::*;
#(
  parameter int unsigned WIDTH     = SA_WIDTH,
  parameter int unsigned HPE       = SA_HPE,
  parameter int unsigned VPE       = SA_VPE,
  parameter int unsigned FLUSH_LEN = flush_len(HPE, VPE)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [WIDTH*HPE-1:0] in_a,
  input  logic [WIDTH*VPE-1:0] in_b,
  output logic [WIDTH*HPE-1:0] AA,
  output logic [WIDTH*VPE-1:0] BB,
  output logic                 busy,
  output logic                 frame_done
`ifdef SKEW_STATS_EN
  ,
  output logic [15:0]          vec_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_LEN + 1);

  skw_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             accept;
  logic [WIDTH*HPE-1:0] head_a;
  logic [WIDTH*VPE-1:0] head_b;

  assign in_ready = (state_q != SKW_FLUSH);
  assign busy     = (state_q != SKW_IDLE);
  assign accept   = in_valid & in_ready;

  // Bubbles, stalls and the drain all inject zeros at the chain heads.
  assign head_a = accept ? in_a : '0;
  assign head_b = accept ? in_b : '0;

  // State, drain counter and completion pulse registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= SKW_IDLE;
      cnt_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_done <= done_d;
    end
  end

  // Next-state, drain counter and completion decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      SKW_IDLE: begin
        if (accept) begin
          state_d = in_last ? SKW_FLUSH : SKW_STREAM;
          cnt_d   = '0;
        end
      end
      SKW_STREAM: begin
        if (accept && in_last) begin
          state_d = SKW_FLUSH;
          cnt_d   = '0;
        end
      end
      SKW_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          state_d = SKW_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SKW_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SKEW_STATS_EN
  // Per-frame accept counter: restarts at 1 on the first accept of a frame,
  // saturates, and holds through the drain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vec_count <= '0;
    end else if (accept) begin
      if (state_q == SKW_IDLE) begin
        vec_count <= 16'd1;
      end else if (vec_count != 16'hFFFF) begin
        vec_count <= vec_count + 16'd1;
      end
    end
  end
`endif

  // A lane i: i+1 stages.
  for (genvar i = 0; i < HPE; i++) begin : g_a_lane
    sa_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(i + 1)
    ) u_dl (
      .clk  (CLK),
      .rst_n(RST),
      .din  (head_a[i*WIDTH +: WIDTH]),
      .dout (AA[i*WIDTH +: WIDTH])
    );
  end

  // B lane j: j+1 stages.
  for (genvar j = 0; j < VPE; j++) begin : g_b_lane
    sa_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(j + 1)
    ) u_dl (
      .clk  (CLK),
      .rst_n(RST),
      .din  (head_b[j*WIDTH +: WIDTH]),
      .dout (BB[j*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_operand_skewer.sv
// Self-checking bench for sa_operand_skewer (WIDTH=8, HPE=VPE=4).
// Every driven accept pushes the expected byte for each lane, tagged with the
// clock edge after which that lane must show it; a negedge monitor pops and
// compares all eight lanes every cycle (no entry due means the lane must be 0).
module tb_sa_operand_skewer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int FL = 2 * N - 1;

  logic           CLK = 1'b0;
  logic           RST;
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [W*N-1:0] in_a;
  logic [W*N-1:0] in_b;
  logic [W*N-1:0] AA;
  logic [W*N-1:0] BB;
  logic           busy;
  logic           frame_done;
`ifdef SKEW_STATS_EN
  logic [15:0]    vec_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t scb [8][$];

  sa_operand_skewer #(
    .WIDTH(W),
    .HPE  (N),
    .VPE  (N)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .AA        (AA),
    .BB        (BB),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef SKEW_STATS_EN
    ,
    .vec_count (vec_count)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  // Lane monitor: lanes 0..3 are AA, 4..7 are BB.
  always @(negedge CLK) begin : mon
    logic [7:0] act;
    logic [7:0] expv;
    exp_t       e;
    for (int l = 0; l < 8; l++) begin
      if (l < N) act = AA[l*W +: W];
      else       act = BB[(l-N)*W +: W];
      expv = 8'h00;
      if (scb[l].size() > 0) begin
        if (scb[l][0].due == edge_n) begin
          e    = scb[l].pop_front();
          expv = e.val;
        end
      end
      n_checks++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL lane%0d edge %0d: got %02h expected %02h", l, edge_n, act, expv);
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one vector pair for a cycle; valid pairs are assumed accepted.
  task automatic send(input logic v, input logic last,
                      input logic [W*N-1:0] a, input logic [W*N-1:0] b);
    exp_t e;
    in_valid = v;
    in_last  = last;
    in_a     = a;
    in_b     = b;
    if (v) begin
      for (int i = 0; i < N; i++) begin
        e.due = edge_n + 1 + i;
        e.val = a[i*W +: W];
        scb[i].push_back(e);
        e.val = b[i*W +: W];
        scb[N+i].push_back(e);
      end
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Returns the edge after which frame_done was seen high, or -1 on timeout.
  task automatic wait_frame_done(output int at_edge);
    at_edge = -1;
    for (int k = 0; k < 40; k++) begin
      if (frame_done === 1'b1) begin
        at_edge = edge_n;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    RST      = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'hCAFEF00D;
    repeat (3) tick();
    n_checks++;
    if (AA !== '0 || BB !== '0) begin
      n_fail++; $display("FAIL reset_data: AA=%h BB=%h expected 0", AA, BB);
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b expected 1 0 0", in_ready, busy, frame_done);
    end
`ifdef SKEW_STATS_EN
    n_checks++;
    if (vec_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_vec_count: got %0d expected 0", vec_count);
    end
`endif
    in_valid = 1'b0;
    RST      = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_accept: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    int acc;
    int de;
    acc = edge_n + 1;
    send(1'b1, 1'b1, 32'h04030201, 32'h40302010);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_flush_state: busy=%b ready=%b expected 1 0", busy, in_ready);
    end
    wait_frame_done(de);
    n_checks++;
    if (de != acc + FL) begin
      n_fail++; $display("FAIL single_done_edge: got %0d expected %0d", de, acc + FL);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done_busy: busy=%b expected 0", busy);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_pulse: frame_done=%b expected 0", frame_done);
    end
  endtask

  task automatic test_burst();
    int acc;
    int de;
    send(1'b1, 1'b0, 32'hA1B2C311, 32'h01020304);
    send(1'b1, 1'b0, 32'hA4B5C622, 32'h05060708);
    acc = edge_n + 1;
    send(1'b1, 1'b1, 32'hA7B8C933, 32'h090A0B0C);
    wait_frame_done(de);
    n_checks++;
    if (de != acc + FL) begin
      n_fail++; $display("FAIL burst_done_edge: got %0d expected %0d", de, acc + FL);
    end
`ifdef SKEW_STATS_EN
    n_checks++;
    if (vec_count !== 16'd3) begin
      n_fail++; $display("FAIL burst_vec_count: got %0d expected 3", vec_count);
    end
`endif
    tick();
  endtask

  task automatic test_bubble();
    int acc;
    int de;
    send(1'b1, 1'b0, 32'h5A6B7C8D, 32'h11223344);
    send(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bubble_stream: busy=%b ready=%b expected 1 1", busy, in_ready);
    end
    acc = edge_n + 1;
    send(1'b1, 1'b1, 32'h9EAFB0C1, 32'h55667788);
    wait_frame_done(de);
    n_checks++;
    if (de != acc + FL) begin
      n_fail++; $display("FAIL bubble_done_edge: got %0d expected %0d", de, acc + FL);
    end
`ifdef SKEW_STATS_EN
    n_checks++;
    if (vec_count !== 16'd2) begin
      n_fail++; $display("FAIL bubble_vec_count: got %0d expected 2", vec_count);
    end
`endif
    tick();
  endtask

  // Valid held through FLUSH must not be consumed; the held pair goes in the
  // frame_done cycle, so frames run back to back.
  task automatic test_back_to_back();
    int acc;
    int de;
    acc = edge_n + 1;
    send(1'b1, 1'b1, 32'h13243546, 32'h5768798A);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_a     = 32'hE1E2E3E4;
    in_b     = 32'hD1D2D3D4;
    for (int j = 0; j < FL; j++) begin
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_flush_hold[%0d]: ready=%b busy=%b done=%b expected 0 1 0",
                 j, in_ready, busy, frame_done);
      end
      tick();
    end
    n_checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1 || edge_n != acc + FL) begin
      n_fail++;
      $display("FAIL b2b_done_cycle: done=%b ready=%b edge=%0d expected 1 1 %0d",
               frame_done, in_ready, edge_n, acc + FL);
    end
    acc = edge_n + 1;
    send(1'b1, 1'b1, 32'hE1E2E3E4, 32'hD1D2D3D4);
    wait_frame_done(de);
    n_checks++;
    if (de != acc + FL) begin
      n_fail++; $display("FAIL b2b_second_done: got %0d expected %0d", de, acc + FL);
    end
`ifdef SKEW_STATS_EN
    n_checks++;
    if (vec_count !== 16'd1) begin
      n_fail++; $display("FAIL b2b_vec_count: got %0d expected 1", vec_count);
    end
`endif
    tick();
  endtask

  task automatic test_async_reset();
    logic seen_done;
    for (int v = 0; v < 5; v++) begin
      send(1'b1, (v == 4), 32'h0F0E0D0C + 32'(v), 32'h70605040 + 32'(v));
    end
`ifdef SKEW_STATS_EN
    n_checks++;
    if (vec_count !== 16'd5) begin
      n_fail++; $display("FAIL areset_vec_count: got %0d expected 5", vec_count);
    end
`endif
    repeat (2) tick();
    RST = 1'b0;
    for (int l = 0; l < 8; l++) scb[l].delete();
    #1;
    n_checks++;
    if (AA !== '0 || BB !== '0) begin
      n_fail++; $display("FAIL areset_data: AA=%h BB=%h expected 0", AA, BB);
    end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_ctrl: busy=%b ready=%b done=%b expected 0 1 0", busy, in_ready, frame_done);
    end
`ifdef SKEW_STATS_EN
    n_checks++;
    if (vec_count !== 16'd0) begin
      n_fail++; $display("FAIL areset_vec_clear: got %0d expected 0", vec_count);
    end
`endif
    repeat (2) tick();
    RST = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (frame_done === 1'b1) seen_done = 1'b1;
      tick();
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++; $display("FAIL areset_no_done: frame_done pulsed after abort, expected none");
    end
  endtask

  initial begin
    RST      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    test_reset();
    test_single();
    test_burst();
    test_bubble();
    test_back_to_back();
    test_async_reset();
    repeat (10) tick();
    for (int l = 0; l < 8; l++) begin
      n_checks++;
      if (scb[l].size() != 0) begin
        n_fail++; $display("FAIL drain_lane%0d: %0d entries left, expected 0", l, scb[l].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
